// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: FSM encodings, funct3 codes, helpers.
// Optional LSU_TIMEOUT_EN build adds a REQ-cycle watchdog in mem_access_unit.
package lsu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int LSU_TIMEOUT_MAX = 255;

    // Instruction context held for the whole transaction.
    typedef struct packed {
        logic [31:0] alu;
        logic [2:0]  funct3;
        logic [4:0]  wr;
        logic        reg_write;
        logic        mem_reg;
        logic        is_load;
    } lsu_req_t;

    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Size lives in funct3[1:0] for both loads and stores.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~lo[0];
            2'b10:   return lo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction: picks byte/half by address and extends.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: IDLE -> REQ -> DONE handshake with a word bus.
// Define LSU_TIMEOUT_EN to abort a request after LSU_TIMEOUT_MAX wait cycles.
module mem_access_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] store_data_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  wr_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_reg_in,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_out,
    output logic [4:0]  wr_out,
    output logic        reg_write_out,
    output logic        mem_reg_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    logic [1:0]  state;
    lsu_req_t    req_q;
    logic [31:0] data_q;
    logic [31:0] load_data;
    logic        access, legal, start;

    assign access       = valid_in && (mem_read_in || mem_write_in);
    assign legal        = f3_legal(funct3_in, mem_write_in) &&
                          addr_aligned(funct3_in, alu_in[1:0]);
    assign start        = (state == ST_IDLE) && access && legal;
    assign misalign_out = (state == ST_IDLE) && access && !legal;
    assign stall_out    = start || (state == ST_REQ);

    load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (req_q.alu[1:0]),
        .funct3  (req_q.funct3),
        .data    (load_data)
    );

`ifdef LSU_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;
    assign bus_err_out = err_q;
`else
    assign bus_err_out = 1'b0;
`endif

    // DONE replays the latched instruction; elsewhere EX/MEM flows straight through,
    // with writeback suppressed while stalled or on a rejected access.
    always_comb begin
        read_data_out = '0;
        alu_out       = alu_in;
        wr_out        = wr_in;
        mem_reg_out   = mem_reg_in;
        reg_write_out = reg_write_in && !stall_out && !misalign_out;
        if (state == ST_DONE) begin
            read_data_out = data_q;
            alu_out       = req_q.alu;
            wr_out        = req_q.wr;
            mem_reg_out   = req_q.mem_reg;
            reg_write_out = req_q.reg_write && !bus_err_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            data_q    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= mem_write_in;
                        mem_be    <= lane_mask(funct3_in, alu_in[1:0]);
                        mem_addr  <= {alu_in[31:2], 2'b00};
                        mem_wdata <= store_lanes(funct3_in, store_data_in);
                        req_q     <= '{alu: alu_in, funct3: funct3_in, wr: wr_in,
                                       reg_write: reg_write_in, mem_reg: mem_reg_in,
                                       is_load: !mem_write_in};
`ifdef LSU_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        state   <= ST_DONE;
                        data_q  <= req_q.is_load ? load_data : 32'd0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == 8'(LSU_TIMEOUT_MAX - 1)) begin
                        state   <= ST_DONE;
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
`ifdef LSU_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: IDLE decode table plus bus handshake sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, reg_write_in, mem_read_in, mem_write_in, mem_reg_in;
    logic [31:0] alu_in, store_data_in, mem_rdata;
    logic [2:0]  funct3_in;
    logic [4:0]  wr_in;
    logic        mem_ready;
    logic [31:0] read_data_out, alu_out, mem_addr, mem_wdata;
    logic [4:0]  wr_out;
    logic        reg_write_out, mem_reg_out, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic        stall_out, misalign_out, bus_err_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_in(alu_in),
        .store_data_in(store_data_in), .funct3_in(funct3_in), .wr_in(wr_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_reg_in(mem_reg_in),
        .read_data_out(read_data_out), .alu_out(alu_out), .wr_out(wr_out),
        .reg_write_out(reg_write_out), .mem_reg_out(mem_reg_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .stall_out(stall_out),
        .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 0; mem_read_in = 0; mem_write_in = 0; reg_write_in = 0;
        mem_reg_in = 0; alu_in = 0; store_data_in = 0; funct3_in = 0; wr_in = 0;
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [2:0]  f3;
        logic [4:0]  wr;
        logic        rw, mrd, mwr, mreg;
        logic        e_stall, e_mis, e_rw;
    } vec_t;

    // One memory transaction; checks bus fields on the first REQ cycle and outputs in DONE.
    task automatic access_seq(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sd, input logic is_store, input logic [31:0] rdata,
                              input int ready_at, input logic [31:0] exp_rd, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input int exp_stalls);
        int  stalls = 0;
        int  reqc   = 0;
        bit  done   = 0;
        @(posedge clk); #1;
        valid_in = 1; alu_in = addr; store_data_in = sd; funct3_in = f3; wr_in = 5'd9;
        mem_read_in = !is_store; mem_write_in = is_store;
        reg_write_in = !is_store; mem_reg_in = !is_store;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                reqc++;
                if (reqc == 1) begin
                    chk({name, " addr"}, mem_addr, {addr[31:2], 2'b00});
                    chk({name, " we"}, 32'(mem_we), 32'(is_store));
                    if (is_store) begin
                        chk({name, " be"}, 32'(mem_be), 32'(exp_be));
                        chk({name, " wdata"}, mem_wdata, exp_wdata);
                    end
                end
                mem_ready = (reqc == ready_at);
                mem_rdata = rdata;
            end else if (reqc > 0) begin
                done = 1;
                chk({name, " done stall"}, 32'(stall_out), 32'd0);
                chk({name, " wr_out"}, 32'(wr_out), 32'd9);
                chk({name, " reg_write"}, 32'(reg_write_out), 32'(!is_store));
                if (!is_store) begin
                    chk({name, " rdata"}, read_data_out, exp_rd);
                    chk({name, " mem_reg"}, 32'(mem_reg_out), 32'd1);
                end
            end
            if (stall_out) stalls++;
        end
        if (!done) chk({name, " completion timeout"}, 32'd0, 32'd1);
        chk({name, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
        mem_ready = 0;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    vec_t vecs[12];

    initial begin
        // valid alu f3 wr rw mrd mwr mreg | stall mis rw_out
        vecs[0]  = '{1, 32'h12345678, 3'b000, 5'd7,  1, 0, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 32'h00000101, 3'b010, 5'd3,  1, 1, 0, 1, 0, 0, 1};
        vecs[2]  = '{1, 32'h00000100, 3'b010, 5'd4,  1, 1, 0, 1, 1, 0, 0};
        vecs[3]  = '{1, 32'h00000101, 3'b010, 5'd5,  1, 1, 0, 1, 0, 1, 0};
        vecs[4]  = '{1, 32'h00000103, 3'b001, 5'd6,  1, 1, 0, 1, 0, 1, 0};
        vecs[5]  = '{1, 32'h00000102, 3'b001, 5'd8,  1, 1, 0, 1, 1, 0, 0};
        vecs[6]  = '{1, 32'h00000103, 3'b000, 5'd10, 1, 1, 0, 1, 1, 0, 0};
        vecs[7]  = '{1, 32'h00000100, 3'b011, 5'd11, 1, 1, 0, 1, 0, 1, 0};
        vecs[8]  = '{1, 32'h00000003, 3'b000, 5'd12, 0, 0, 1, 0, 1, 0, 0};
        vecs[9]  = '{1, 32'h00000000, 3'b100, 5'd13, 0, 0, 1, 0, 0, 1, 0};
        vecs[10] = '{1, 32'h00000202, 3'b010, 5'd14, 0, 0, 1, 0, 0, 1, 0};
        vecs[11] = '{1, 32'h00000101, 3'b101, 5'd15, 1, 1, 0, 1, 0, 1, 0};

        idle_inputs();
        mem_ready = 0; mem_rdata = 0;
        reset = 0;
        #12;
        chk("reset mem_req", 32'(mem_req), 0);
        chk("reset mem_we", 32'(mem_we), 0);
        chk("reset mem_be", 32'(mem_be), 0);
        chk("reset stall", 32'(stall_out), 0);
        chk("reset misalign", 32'(misalign_out), 0);
        chk("reset bus_err", 32'(bus_err_out), 0);
        chk("reset read_data", read_data_out, 0);
        @(posedge clk); #1 reset = 1;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            valid_in = vecs[i].valid; alu_in = vecs[i].alu; funct3_in = vecs[i].f3;
            wr_in = vecs[i].wr; reg_write_in = vecs[i].rw; mem_read_in = vecs[i].mrd;
            mem_write_in = vecs[i].mwr; mem_reg_in = vecs[i].mreg;
            #2;
            chk($sformatf("vec%0d stall", i), 32'(stall_out), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d misalign", i), 32'(misalign_out), 32'(vecs[i].e_mis));
            chk($sformatf("vec%0d reg_write", i), 32'(reg_write_out), 32'(vecs[i].e_rw));
            chk($sformatf("vec%0d alu_out", i), alu_out, vecs[i].alu);
            chk($sformatf("vec%0d wr_out", i), 32'(wr_out), 32'(vecs[i].wr));
            chk($sformatf("vec%0d mem_reg", i), 32'(mem_reg_out), 32'(vecs[i].mreg));
            idle_inputs();
        end

        access_seq("LW 0x100",  3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 0, 0, 4);
        access_seq("LB 0x103",  3'b000, 32'h103, 0, 0, 32'h80112233, 1, 32'hFFFFFF80, 0, 0, 2);
        access_seq("LBU 0x103", 3'b100, 32'h103, 0, 0, 32'h80112233, 1, 32'h00000080, 0, 0, 2);
        access_seq("LH 0x102",  3'b001, 32'h102, 0, 0, 32'h80112233, 2, 32'hFFFF8011, 0, 0, 3);
        access_seq("LHU 0x100", 3'b101, 32'h100, 0, 0, 32'h80119233, 1, 32'h00009233, 0, 0, 2);
        access_seq("SH 0x202",  3'b001, 32'h202, 32'h0000ABCD, 1, 0, 1, 0, 4'b1100, 32'hABCDABCD, 2);
        access_seq("SB 0x201",  3'b000, 32'h201, 32'h1234565A, 1, 0, 2, 0, 4'b0010, 32'h5A5A5A5A, 3);
        access_seq("SW 0x300",  3'b010, 32'h300, 32'h12345678, 1, 0, 1, 0, 4'b1111, 32'h12345678, 2);

        // Misaligned word held for several cycles never reaches the bus.
        @(posedge clk); #1;
        valid_in = 1; mem_read_in = 1; funct3_in = 3'b010; alu_in = 32'h101;
        reg_write_in = 1; mem_reg_in = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("misalign hold mem_req", 32'(mem_req), 0);
            chk("misalign hold flag", 32'(misalign_out), 1);
            chk("misalign hold stall", 32'(stall_out), 0);
            chk("misalign hold reg_write", 32'(reg_write_out), 0);
        end
        idle_inputs();

        // Reset in the middle of REQ, then a stray mem_ready.
        @(posedge clk); #1;
        valid_in = 1; mem_read_in = 1; funct3_in = 3'b010; alu_in = 32'h400;
        reg_write_in = 1; mem_reg_in = 1;
        @(negedge clk);
        @(negedge clk);
        chk("mid-REQ mem_req up", 32'(mem_req), 1);
        #2;
        idle_inputs();
        reset = 0;
        #1;
        chk("async reset mem_req", 32'(mem_req), 0);
        chk("async reset stall", 32'(stall_out), 0);
        chk("async reset mem_be", 32'(mem_be), 0);
        @(posedge clk); #1;
        reset = 1; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("late ready mem_req", 32'(mem_req), 0);
            chk("late ready stall", 32'(stall_out), 0);
            chk("late ready read_data", read_data_out, 0);
        end
        mem_ready = 0;

`ifdef LSU_TIMEOUT_EN
        begin
            int  reqc = 0;
            bit  dropped = 0;
            @(posedge clk); #1;
            valid_in = 1; mem_read_in = 1; funct3_in = 3'b010; alu_in = 32'h500;
            reg_write_in = 1; mem_reg_in = 1; wr_in = 5'd2;
            @(negedge clk);
            for (int c = 0; c < 400 && !dropped; c++) begin
                @(negedge clk);
                if (mem_req) reqc++;
                else dropped = 1;
            end
            chk("timeout req cycles", 32'(reqc), 32'd255);
            chk("timeout bus_err", 32'(bus_err_out), 1);
            chk("timeout reg_write", 32'(reg_write_out), 0);
            chk("timeout read_data", read_data_out, 0);
            idle_inputs();
            @(negedge clk);
            chk("timeout back idle stall", 32'(stall_out), 0);
            chk("timeout err cleared", 32'(bus_err_out), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
